fir_band_sched: RTL and testbench
=================================

Name: fir_band_sched

Overview:
Scheduler that sequences the equalizer's FIR band filters, one at a time, for each new audio frame. When the high-frequency sample queue signals a fresh frame, the block walks the enabled bands in ascending index order. For each band it issues a one-cycle start, then waits for that band's done or a timeout. It sits between the queue's frame-ready strobe and the per-band FIR start/done handshakes. It also reports frame completion, dropped frames and hung bands.

Parameters:
NUM_BANDS, 5, number of FIR bands scheduled (B1..B5).
TIMEOUT, 2048, cycles allowed in WAIT before a band is declared hung; must be >= 2.
CNT_W, 8, width of the saturating overrun counter.

Ports:
clk  input  1  system clock
RST_n  input  1  reset, asynchronous, active-low
frame_rdy  input  1  one-cycle pulse: new frame available in the sample queues
band_en  input  NUM_BANDS  per-band enable mask; sampled only when a frame is accepted
band_done  input  NUM_BANDS  per-band completion pulse
band_start  output  NUM_BANDS  one-hot, one-cycle start pulse to the selected band
band_sel  output  $clog2(NUM_BANDS)  index of the band currently started or awaited
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse when all enabled bands have finished for the frame
ovr_cnt  output  CNT_W  saturating count of frames dropped while busy
tmo  output  1  one-cycle pulse when a band times out
tmo_band  output  $clog2(NUM_BANDS)  index of the most recent timed-out band; holds its value

Behaviour:
- Reset (RST_n low, asynchronous):
  - state = IDLE.
  - band_start, frame_done, tmo, busy = 0.
  - band_sel, tmo_band, ovr_cnt, pending mask, timer = 0.
  - Reset asserted mid-frame aborts the frame immediately; no frame_done is issued.
- States: IDLE, START, WAIT, DONE.
- IDLE:
  - On frame_rdy: pend <= band_en.
  - If band_en == 0, go to DONE; otherwise go to START.
- START (exactly 1 cycle):
  - idx = lowest set bit of pend.
  - band_start[idx] = 1 (all other bits 0); band_sel <= idx.
  - Clear pend[idx]; timer <= 0; go to WAIT.
- WAIT:
  - The timer increments every cycle.
  - Only band_done[band_sel] is observed; done bits of other bands are ignored.
  - On done, or when timer == TIMEOUT-1:
    - On a timeout without done, pulse tmo and set tmo_band <= band_sel.
    - If pend != 0, go to START; otherwise go to DONE.
  - If done and timeout occur in the same cycle, done wins and no tmo is raised.
- DONE (1 cycle): frame_done = 1, then go to IDLE.
- Handshake rule: band_done is sampled only in WAIT. A done arriving in the same cycle as its band_start is lost, so bands must respond no earlier than 1 cycle after start.
- Overrun:
  - frame_rdy in any state other than IDLE (START, WAIT or DONE) drops the frame.
  - ovr_cnt increments and saturates at 2^CNT_W-1; it clears only on reset.
- Latency:
  - frame_rdy at cycle 0 gives the first band_start at cycle 1.
  - done at cycle k with more bands pending gives the next band_start at cycle k+1.
  - done of the last band at cycle k gives frame_done at cycle k+1.
  - With an empty mask, frame_done is at cycle 1.
- band_en changes mid-frame have no effect until the next accepted frame.
- busy is registered and equals (state != IDLE).

Decomposition:
- Shared package eq_pkg holds:
  - the sched_state_t enum {IDLE, START, WAIT, DONE};
  - the NUM_BANDS default;
  - a BAND_IDX_W = $clog2(NUM_BANDS) constant.
- One sub-module, lsb_find: a parameterized combinational lowest-set-bit encoder over NUM_BANDS bits, producing an index and a valid flag.
- The FSM, timer and counters stay in fir_band_sched.

Test Plan:
- All enabled: band_en=5'b11111, frame_rdy pulse, each band returns done 3 cycles after its start -> starts on bands 0,1,2,3,4 in order; frame_done exactly 1 cycle after band 4's done; busy high throughout.
- Sparse mask: band_en=5'b10100 -> only band_start[2] then band_start[4]; band_sel=2 then 4; no other start bits ever set.
- Empty mask: band_en=0, frame_rdy at cycle 0 -> frame_done at cycle 1; band_start stays 0.
- Hung band: band 1 never asserts done, TIMEOUT=16 -> tmo pulses 16 cycles after band_start[1]; tmo_band=1; band 2 starts on the next cycle; the frame still completes.
- Overrun: pulse frame_rdy 3 times while busy -> ovr_cnt=3. With CNT_W=2, 5 drops -> ovr_cnt=3 (saturated).
- Reset mid-WAIT: drop RST_n while waiting on band 2 -> all outputs 0 immediately. After release, a new frame_rdy starts again from the lowest enabled band, and no stale frame_done appears.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer band scheduler.
//   sched_state_t : scheduler FSM states
//   NUM_BANDS_DEF : default number of FIR bands
//   BAND_IDX_W    : width of a band index for the default band count
package eq_pkg;

  localparam int NUM_BANDS_DEF = 5;
  localparam int BAND_IDX_W    = $clog2(NUM_BANDS_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/lsb_find.sv
// Lowest-set-bit encoder.
//   vec_i   : input bit vector
//   idx_o   : index of the lowest set bit (0 when vec_i is all zero)
//   valid_o : high when any bit of vec_i is set
module lsb_find #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |vec_i;

endmodule

// File: rtl/fir_band_sched.sv
// Sequences the equalizer FIR bands one at a time for each new audio frame.
//   clk, RST_n  : clock, asynchronous active-low reset
//   frame_rdy   : new-frame strobe from the sample queue
//   band_en     : enable mask, captured when a frame is accepted
//   band_done   : per-band completion pulses
//   band_start  : one-hot start pulse to the selected band
//   band_sel    : index of the band being started/awaited
//   busy        : scheduler not idle (registered)
//   frame_done  : all enabled bands finished for the frame
//   ovr_cnt     : saturating count of frames dropped while busy
//   tmo, tmo_band : band timeout pulse and index of the last hung band
//
// state | meaning
// IDLE  | waiting for frame_rdy
// START | pulse band_start for lowest pending band (1 cycle)
// WAIT  | waiting for that band's done or timeout
// DONE  | pulse frame_done (1 cycle)
module fir_band_sched
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = NUM_BANDS_DEF,
  parameter int TIMEOUT   = 2048,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = $clog2(NUM_BANDS),
  localparam int TMR_W    = $clog2(TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 RST_n,
  input  logic                 frame_rdy,
  input  logic [NUM_BANDS-1:0] band_en,
  input  logic [NUM_BANDS-1:0] band_done,
  output logic [NUM_BANDS-1:0] band_start,
  output logic [IDX_W-1:0]     band_sel,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     ovr_cnt,
  output logic                 tmo,
  output logic [IDX_W-1:0]     tmo_band
);

  sched_state_t         state_q, state_d;
  logic [NUM_BANDS-1:0] pend_q, pend_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [IDX_W-1:0]     tmo_band_q, tmo_band_d;
  logic [CNT_W-1:0]     ovr_q, ovr_d;
  logic                 busy_q;

  logic [IDX_W-1:0]     lsb_idx;
  logic                 lsb_vld;
  logic                 done_seen;
  logic                 tmr_exp;

  lsb_find #(
    .N     (NUM_BANDS),
    .IDX_W (IDX_W)
  ) u_lsb_find (
    .vec_i   (pend_q),
    .idx_o   (lsb_idx),
    .valid_o (lsb_vld)
  );

  assign done_seen = band_done[sel_q];
  assign tmr_exp   = (tmr_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    sel_d      = sel_q;
    tmr_d      = tmr_q;
    tmo_band_d = tmo_band_q;
    band_start = '0;
    frame_done = 1'b0;
    tmo        = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_rdy) begin
          pend_d  = band_en;
          state_d = (band_en == '0) ? DONE : START;
        end
      end
      START: begin
        band_start = lsb_vld ? (NUM_BANDS'(1) << lsb_idx) : '0;
        sel_d      = lsb_idx;
        pend_d     = pend_q & ~(NUM_BANDS'(1) << lsb_idx);
        tmr_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        tmr_d = tmr_q + 1'b1;
        if (done_seen || tmr_exp) begin
          // done in the same cycle as expiry counts as a normal finish
          if (!done_seen) begin
            tmo        = 1'b1;
            tmo_band_d = sel_q;
          end
          state_d = (pend_q != '0) ? START : DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A frame offered while a previous one is still being processed is dropped.
  always_comb begin
    ovr_d = ovr_q;
    if (frame_rdy && (state_q != IDLE) && (ovr_q != {CNT_W{1'b1}})) begin
      ovr_d = ovr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      sel_q      <= '0;
      tmr_q      <= '0;
      tmo_band_q <= '0;
      ovr_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      sel_q      <= sel_d;
      tmr_q      <= tmr_d;
      tmo_band_q <= tmo_band_d;
      ovr_q      <= ovr_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign band_sel = sel_q;
  assign busy     = busy_q;
  assign ovr_cnt  = ovr_q;
  assign tmo_band = tmo_band_q;

endmodule

// File: tb/tb_fir_band_sched.sv
module tb_fir_band_sched;
  import eq_pkg::*;

  localparam int NB = NUM_BANDS_DEF;
  localparam int IW = BAND_IDX_W;
  localparam int CW = 2;

  typedef enum int {EV_START, EV_DONE, EV_TMO} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       idx;
    int       cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          RST_n = 1'b0;
  logic          frame_rdy = 1'b0;
  logic [NB-1:0] band_en = '0;
  logic [NB-1:0] band_done = '0;
  logic [NB-1:0] band_start;
  logic [IW-1:0] band_sel;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] ovr_cnt;
  logic          tmo;
  logic [IW-1:0] tmo_band;

  fir_band_sched #(
    .NUM_BANDS (NB),
    .TIMEOUT   (16),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .RST_n      (RST_n),
    .frame_rdy  (frame_rdy),
    .band_en    (band_en),
    .band_done  (band_done),
    .band_start (band_start),
    .band_sel   (band_sel),
    .busy       (busy),
    .frame_done (frame_done),
    .ovr_cnt    (ovr_cnt),
    .tmo        (tmo),
    .tmo_band   (tmo_band)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(ev_kind_t k, int v, int i, int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.idx  = i;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Band responder: band b raises done dly[b] cycles after its start (0 = never).
  int dly[NB];
  int done_at[NB] = '{default: -1};
  bit resp_clr = 1'b0;

  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (resp_clr) done_at[b] <= -1;
      else if (band_start[b] && dly[b] > 0) done_at[b] <= cyc + dly[b];
    end
  end

  always @(posedge clk) begin
    #1;
    for (int b = 0; b < NB; b++) band_done[b] = (done_at[b] == cyc);
  end

  // Monitor: pop and compare whenever the DUT presents an event.
  bit sel_pend = 1'b0;
  bit tb_pend = 1'b0;
  int sel_exp = 0;
  int tb_exp = 0;

  task automatic take(ev_kind_t k, int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected event %s value %0d at cycle %0d", k.name(), v, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event kind", 32'(k), 32'(e.kind));
    chk("event value", 32'(v), 32'(e.val));
    chk("event cycle", 32'(cyc), 32'(e.cyc));
    if (k == EV_START) begin sel_pend = 1'b1; sel_exp = e.idx; end
    if (k == EV_TMO)   begin tb_pend = 1'b1;  tb_exp = e.idx;  end
  endtask

  always @(negedge clk) begin
    if (RST_n) begin
      if (sel_pend) begin chk("band_sel", 32'(band_sel), 32'(sel_exp)); sel_pend = 1'b0; end
      if (tb_pend)  begin chk("tmo_band", 32'(tmo_band), 32'(tb_exp));  tb_pend = 1'b0;  end
      if (band_start != '0) take(EV_START, int'(band_start));
      if (frame_done) take(EV_DONE, 0);
      if (tmo) take(EV_TMO, 0);
    end
  end

  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rdy();
    frame_rdy = 1'b1;
    @(posedge clk);
    #1;
    frame_rdy = 1'b0;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("events outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " band_start"}, 32'(band_start), 32'd0);
    chk({tag, " band_sel"},   32'(band_sel),   32'd0);
    chk({tag, " busy"},       32'(busy),       32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, " ovr_cnt"},    32'(ovr_cnt),    32'd0);
    chk({tag, " tmo"},        32'(tmo),        32'd0);
    chk({tag, " tmo_band"},   32'(tmo_band),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int c0;

  initial begin
    for (int b = 0; b < NB; b++) dly[b] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    RST_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All bands enabled, each answers 3 cycles after its start.
    for (int b = 0; b < NB; b++) dly[b] = 3;
    c0 = cyc;
    for (int i = 0; i < NB; i++) push(EV_START, 1 << i, i, c0 + 1 + 4 * i);
    push(EV_DONE, 0, 0, c0 + 21);
    band_en = 5'b11111;
    pulse_rdy();
    goto(c0 + 2);  chk("busy all-en early", 32'(busy), 32'd1);
    goto(c0 + 11); chk("busy all-en mid", 32'(busy), 32'd1);
    goto(c0 + 21); chk("busy all-en done", 32'(busy), 32'd1);
    goto(c0 + 22); chk("busy all-en idle", 32'(busy), 32'd0);
    drain(40);

    // Sparse mask: bands 2 and 4 only.
    for (int b = 0; b < NB; b++) dly[b] = 2;
    c0 = cyc;
    push(EV_START, 5'b00100, 2, c0 + 1);
    push(EV_START, 5'b10000, 4, c0 + 4);
    push(EV_DONE, 0, 0, c0 + 7);
    band_en = 5'b10100;
    pulse_rdy();
    drain(30);

    // Empty mask: frame_done the cycle after frame_rdy.
    c0 = cyc;
    push(EV_DONE, 0, 0, c0 + 1);
    band_en = 5'b00000;
    pulse_rdy();
    chk("busy empty mask", 32'(busy), 32'd1);
    drain(10);

    // Band 1 hangs; timeout of 16 cycles, then band 2 proceeds.
    dly[0] = 1; dly[1] = 0; dly[2] = 2;
    c0 = cyc;
    push(EV_START, 5'b00001, 0, c0 + 1);
    push(EV_START, 5'b00010, 1, c0 + 3);
    push(EV_TMO, 0, 1, c0 + 19);
    push(EV_START, 5'b00100, 2, c0 + 20);
    push(EV_DONE, 0, 0, c0 + 23);
    band_en = 5'b00111;
    pulse_rdy();
    drain(60);

    // Overrun: five drops saturate the 2-bit counter; mask change mid-frame ignored.
    for (int b = 0; b < NB; b++) dly[b] = 3;
    c0 = cyc;
    for (int i = 0; i < NB; i++) push(EV_START, 1 << i, i, c0 + 1 + 4 * i);
    push(EV_DONE, 0, 0, c0 + 21);
    band_en = 5'b11111;
    pulse_rdy();
    goto(c0 + 2);  band_en = 5'b00000;
    goto(c0 + 3);  pulse_rdy();
    goto(c0 + 8);  pulse_rdy();
    goto(c0 + 10); chk("ovr_cnt after 2 drops", 32'(ovr_cnt), 32'd2);
    goto(c0 + 12); pulse_rdy();
    goto(c0 + 14); chk("ovr_cnt after 3 drops", 32'(ovr_cnt), 32'd3);
    goto(c0 + 15); pulse_rdy();
    goto(c0 + 21); pulse_rdy();
    goto(c0 + 23); chk("ovr_cnt saturated", 32'(ovr_cnt), 32'd3);
    drain(20);

    // Reset while waiting on band 2; no stale frame_done afterwards.
    dly[0] = 1; dly[1] = 1; dly[2] = 0; dly[3] = 1; dly[4] = 1;
    c0 = cyc;
    push(EV_START, 5'b00001, 0, c0 + 1);
    push(EV_START, 5'b00010, 1, c0 + 3);
    push(EV_START, 5'b00100, 2, c0 + 5);
    band_en = 5'b11111;
    pulse_rdy();
    goto(c0 + 8);
    #2;
    RST_n = 1'b0;
    resp_clr = 1'b1;
    #1;
    chk_all_zero("mid-wait reset");
    chk("starts before reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    RST_n = 1'b1;
    resp_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) dly[b] = 2;
    c0 = cyc;
    push(EV_START, 5'b00100, 2, c0 + 1);
    push(EV_START, 5'b01000, 3, c0 + 4);
    push(EV_DONE, 0, 0, c0 + 7);
    band_en = 5'b01100;
    pulse_rdy();
    drain(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
